// File: rtl/md_unit.sv
// md_unit -- iterative RV32M multiply/divide unit.
//
// Accepts one request in IDLE. It runs 32 shift-add or restoring-divide
// iterations on operand magnitudes, then applies the sign correction and
// pulses done for one cycle, 33 rising edges after the accepting edge.
//
// Configuration macro: MDU_DIV_EN
//   defined   : the divide datapath is built (DIV, DIVU, REM, REMU)
//   undefined : divide ops still take 33 edges but return 0 with no write-back
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-low reset
//   start    in   1  request, sampled only in IDLE
//   op       in   3  RV32M funct3
//   rs1_val  in  32  operand A
//   rs2_val  in  32  operand B
//   rd_addr  in   5  destination register
//   busy     out  1  high whenever not in IDLE
//   done     out  1  one-cycle completion pulse
//   result   out 32  write-back data
//   wb_addr  out  5  write-back address
//   wb_we    out  1  write-back enable
//
// state  | meaning
// S_IDLE | waiting for start; latches operands on accept
// S_MUL  | 32 shift-add iterations, then one sign-fix/result cycle
// S_DIV  | 32 restoring-divide iterations, then one sign-fix/result cycle
// S_DONE | done pulse; result and wb_addr valid

module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wb_addr,
  output logic        wb_we
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] rs1_q, rs2_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt;
  logic        fin;
  logic [63:0] acc;
  logic [31:0] result_q;

  // MULH, MULHSU, DIV and REM read rs1 as signed
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  endfunction

  // MULH, DIV and REM read rs2 as signed
  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  logic        sign_a, sign_b;
  logic [31:0] a_mag, b_mag;

  assign sign_a = a_is_signed(op_q) && rs1_q[31];
  assign sign_b = b_is_signed(op_q) && rs2_q[31];
  assign a_mag  = mag(rs1_q, a_is_signed(op_q));
  assign b_mag  = mag(rs2_q, b_is_signed(op_q));

  // Multiply: acc = {partial, multiplier}; add multiplicand on the LSB, shift right
  logic [32:0] mul_sum;
  logic [63:0] mul_nx, prod;
  logic [31:0] mul_res;

  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? a_mag : 32'd0)};
  assign mul_nx  = {mul_sum, acc[31:1]};
  assign prod    = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  logic [63:0] div_nx;
  logic [31:0] div_res;

`ifdef MDU_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor
  logic [32:0] rem_sh, div_diff;
  logic [31:0] quo, rem;

  assign rem_sh   = {acc[63:32], acc[31]};
  assign div_diff = rem_sh - {1'b0, b_mag};
  assign div_nx   = div_diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};
  // Divide-by-zero remainder falls out of the iteration as |rs1| with rs1's
  // sign restored, i.e. rs1 itself; only the quotient needs forcing.
  assign quo      = (rs2_q == 32'd0) ? 32'hFFFF_FFFF
                  : ((sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0]);
  assign rem      = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  assign div_res  = op_q[1] ? rem : quo;
`else
  assign div_nx  = acc;
  assign div_res = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (start) state_nx = op[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV:  if (fin) state_nx = S_DONE;
      S_DONE:        state_nx = S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= 3'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      rd_q     <= 5'd0;
      cnt      <= 5'd0;
      fin      <= 1'b0;
      acc      <= 64'd0;
      result_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            rs1_q <= rs1_val;
            rs2_q <= rs2_val;
            rd_q  <= rd_addr;
            cnt   <= 5'd31;
            fin   <= 1'b0;
            acc   <= op[2] ? {32'd0, mag(rs1_val, a_is_signed(op))}
                           : {32'd0, mag(rs2_val, b_is_signed(op))};
          end
        end
        S_MUL, S_DIV: begin
          if (!fin) begin
            acc <= (state == S_MUL) ? mul_nx : div_nx;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) fin <= 1'b1;
          end else begin
            result_q <= (state == S_MUL) ? mul_res : div_res;
            fin      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign result  = result_q;
  assign wb_addr = rd_q;

`ifdef MDU_DIV_EN
  assign wb_we = done && (rd_q != 5'd0);
`else
  assign wb_we = done && (rd_q != 5'd0) && !op_q[2];
`endif

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed corner cases plus randomized ops checked
// against a plain-arithmetic RV32M model. Honors MDU_DIV_EN like the RTL.

module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int checks = 0;
  int errors = 0;

`ifdef MDU_DIV_EN
  localparam bit DIVON = 1'b1;
`else
  localparam bit DIVON = 1'b0;
`endif

  md_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_addr (wb_addr),
    .wb_we   (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, zb, p;
    longint unsigned ua, ub, up;
    int              ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    zb = {32'd0, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    if (f[2] && !DIVON) return 32'd0;
    case (f)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * zb; return p[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the
  // edge following DONE, with the DUT back in IDLE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noise,
                        input bit use_lit, input logic [31:0] lit);
    logic [31:0] er;
    logic        ewe;
    bit          early;
    er  = use_lit ? lit : model(f, a, b);
    ewe = (rd != 5'd0) && (!f[2] || DIVON);
    op = f; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    start = noise;
    early = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    chk("no_done_before_33", 32'(early), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_at_33", 32'(done), 32'd1);
    chk("result", result, er);
    chk("wb_addr", 32'(wb_addr), 32'(rd));
    chk("wb_we", 32'(wb_we), 32'(ewe));
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("wb_we_outside_done", 32'(wb_we), 32'd0);
    chk("result_held", result, er);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rr;

    rst = 1'b0; start = 1'b1; op = 3'b001; rs1_val = 32'd5; rs2_val = 32'd7; rd_addr = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wb_we", 32'(wb_we), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_wb_addr", 32'(wb_addr), 32'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0, 1'b1, DIVON ? 32'hFFFF_FFFD : 32'd0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0, 1'b1, DIVON ? 32'hFFFF_FFFF : 32'd0);
    run_op(3'b101, 32'd100, 32'd0, 5'd7, 1'b0, 1'b1, DIVON ? 32'hFFFF_FFFF : 32'd0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b1, 32'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b1,
           DIVON ? 32'h8000_0000 : 32'd0);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd0, 5'd2, 1'b0, 1'b1, DIVON ? 32'hFFFF_FFF9 : 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 5'd0, 1'b0, 1'b1, 32'd12);
    // start held high with changing operands through the whole busy window
    run_op(3'b000, 32'h0000_1234, 32'h0000_0010, 5'd11, 1'b1, 1'b1, 32'h0001_2340);

    // mid-operation reset at edge 20 of a DIV
    op = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd7; rd_addr = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_wb_addr", 32'(wb_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_still_idle", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFE);

    for (int i = 0; i < 20; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      rr = 5'($urandom);
      run_op(rf, ra, rb, rr, 1'($urandom), 1'b0, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
